// File: rtl/uartlite_pkg.sv
// Shared register map, status/control bit positions and channel state types
// for the UART-Lite AXI4-Lite responder.
package uartlite_pkg;

  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_TX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_RST_TX  = 0;
  localparam int CTRL_RST_RX  = 1;
  localparam int CTRL_INTR_EN = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_AW,
    WR_GOT_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_e;

  function automatic logic [31:0] stat_word(input logic rx_valid, input logic rx_full,
                                            input logic tx_empty, input logic tx_full,
                                            input logic intr_en, input logic overrun);
    logic [31:0] w;
    w = '0;
    w[STAT_RX_VALID] = rx_valid;
    w[STAT_RX_FULL]  = rx_full;
    w[STAT_TX_EMPTY] = tx_empty;
    w[STAT_TX_FULL]  = tx_full;
    w[STAT_INTR_EN]  = intr_en;
    w[STAT_OVERRUN]  = overrun;
    return w;
  endfunction

endpackage

// File: rtl/uartlite_responder_fifo.sv
// Synchronous FIFO with push/pop/clear. A pop on empty is ignored; a push on
// full only lands when a pop frees the slot in the same cycle. Clear wins.
module uart_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clr_i,
  input  logic [DATA_W-1:0]          din_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign count_o  = count_q;
  assign dout_o   = mem_q[rd_ptr_q];
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, push_eff} - {{PTR_W{1'b0}}, pop_eff};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_eff && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uartlite_responder.sv
// AXI4-Lite responder exposing the UART-Lite RX/TX FIFOs, STAT and CTRL registers
// to a CPU, with a byte-stream side for a PHY or host model.
module uartlite_responder
  import uartlite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_awaddr,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [3:0]  axi_araddr,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        rx_in_valid,
  input  logic [7:0]  rx_in_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready,
  output logic [7:0]  tx_out_data,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [1:0]  awaddr_q;
  logic [7:0]  wdata_q;
  logic        wstrb0_q;
  logic        commit, ar_hs;
  logic [1:0]  cmt_addr;
  logic [7:0]  cmt_data;
  logic        cmt_strb;
  logic [31:0] rd_word, rdata_q;
  logic        intr_en_q, intr_en_d;
  logic        overrun_q, overrun_d;
  logic        rx_valid_prev_q, tx_empty_prev_q;
  logic        irq_q, irq_d;

  logic             rx_pop, rx_clr, rx_empty, rx_full, rx_valid;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] rx_count;
  logic             tx_push, tx_pop, tx_clr, tx_empty, tx_full;
  logic [7:0]       tx_head;
  logic [CNT_W-1:0] tx_count;
  logic             stat_rd;
  logic             unused_bits;

  // Write channel: AW and W are captured independently; commit once both are present
  always_comb begin
    wr_state_d  = wr_state_q;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    commit      = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        if (axi_awvalid && axi_wvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end else if (axi_awvalid) begin
          wr_state_d = WR_GOT_AW;
        end else if (axi_wvalid) begin
          wr_state_d = WR_GOT_W;
        end
      end
      WR_GOT_AW: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_GOT_W: begin
        axi_awready = 1'b1;
        if (axi_awvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read channel: one outstanding read, data registered at the AR handshake
  always_comb begin
    rd_state_d  = rd_state_q;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    ar_hs       = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        axi_arready = 1'b1;
        if (axi_arvalid) begin
          ar_hs      = 1'b1;
          rd_state_d = RD_VALID;
        end
      end
      RD_VALID: begin
        axi_rvalid = 1'b1;
        if (axi_rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign cmt_addr = (wr_state_q == WR_GOT_AW) ? awaddr_q : axi_awaddr[3:2];
  assign cmt_data = (wr_state_q == WR_GOT_W) ? wdata_q : axi_wdata[7:0];
  assign cmt_strb = (wr_state_q == WR_GOT_W) ? wstrb0_q : axi_wstrb[0];

  assign tx_push   = commit && (cmt_addr == REG_TX) && cmt_strb;
  assign tx_clr    = commit && (cmt_addr == REG_CTRL) && cmt_data[CTRL_RST_TX];
  assign rx_clr    = commit && (cmt_addr == REG_CTRL) && cmt_data[CTRL_RST_RX];
  assign intr_en_d = (commit && (cmt_addr == REG_CTRL)) ? cmt_data[CTRL_INTR_EN] : intr_en_q;

  assign rx_valid = !rx_empty;
  assign rx_pop   = ar_hs && (axi_araddr[3:2] == REG_RX) && rx_valid;
  assign stat_rd  = ar_hs && (axi_araddr[3:2] == REG_STAT);
  // a fresh overrun in the same cycle as a STAT read survives the clear
  assign overrun_d = (overrun_q && !stat_rd) || (rx_in_valid && rx_full && !rx_pop);

  always_comb begin
    rd_word = '0;
    case (axi_araddr[3:2])
      REG_RX:   rd_word = rx_valid ? {24'b0, rx_head} : 32'b0;
      REG_STAT: rd_word = stat_word(rx_valid, rx_full, tx_empty, tx_full, intr_en_q, overrun_q);
      default:  rd_word = '0;
    endcase
  end

  assign irq_d = intr_en_q && ((rx_valid && !rx_valid_prev_q) || (tx_empty && !tx_empty_prev_q));

  assign tx_out_valid = !tx_empty;
  assign tx_out_data  = tx_head;
  assign tx_pop       = tx_out_valid && tx_out_ready;

  assign axi_bresp = RESP_OKAY;
  assign axi_rresp = RESP_OKAY;
  assign axi_rdata = rdata_q;
  assign irq       = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q      <= WR_IDLE;
      rd_state_q      <= RD_IDLE;
      rdata_q         <= '0;
      intr_en_q       <= 1'b0;
      overrun_q       <= 1'b0;
      rx_valid_prev_q <= 1'b0;
      tx_empty_prev_q <= 1'b1;
      irq_q           <= 1'b0;
    end else begin
      wr_state_q      <= wr_state_d;
      rd_state_q      <= rd_state_d;
      if (ar_hs) rdata_q <= rd_word;
      intr_en_q       <= intr_en_d;
      overrun_q       <= overrun_d;
      rx_valid_prev_q <= rx_valid;
      tx_empty_prev_q <= tx_empty;
      irq_q           <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (axi_awvalid && axi_awready) awaddr_q <= axi_awaddr[3:2];
    if (axi_wvalid && axi_wready) begin
      wdata_q  <= axi_wdata[7:0];
      wstrb0_q <= axi_wstrb[0];
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_in_valid),
    .pop_i   (rx_pop),
    .clr_i   (rx_clr),
    .din_i   (rx_in_data),
    .dout_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .count_o (rx_count)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .clr_i   (tx_clr),
    .din_i   (cmt_data),
    .dout_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .count_o (tx_count)
  );

  assign unused_bits = ^{axi_awaddr[1:0], axi_araddr[1:0], axi_wdata[31:8], axi_wstrb[3:1],
                         rx_count, tx_count};

endmodule

// File: tb/tb_uartlite_responder.sv
// Directed bench for uartlite_responder: read data is scored against a queue of
// expectations filled from a small model of the FIFOs and status flags.
module tb_uartlite_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axi_awvalid = 1'b0, axi_awready;
  logic [3:0]  axi_awaddr = '0;
  logic        axi_wvalid = 1'b0, axi_wready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_bvalid, axi_bready = 1'b0;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid = 1'b0, axi_arready;
  logic [3:0]  axi_araddr = '0;
  logic        axi_rvalid, axi_rready = 1'b0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        rx_in_valid = 1'b0;
  logic [7:0]  rx_in_data = '0;
  logic        tx_out_valid, tx_out_ready = 1'b0;
  logic [7:0]  tx_out_data;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rx_m[$];
  logic [7:0]  tx_m[$];
  bit          intr_en_m = 1'b0;
  bit          overrun_m = 1'b0;

  always #5 clk = ~clk;

  uartlite_responder #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data),
    .tx_out_valid(tx_out_valid), .tx_out_ready(tx_out_ready), .tx_out_data(tx_out_data),
    .irq(irq)
  );

  function automatic logic [31:0] stat_model();
    return {26'b0, overrun_m, intr_en_m, (tx_m.size() == 16), (tx_m.size() == 0),
            (rx_m.size() == 16), (rx_m.size() != 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    if (rx_m.size() < 16) rx_m.push_back(b);
    else overrun_m = 1'b1;
    rx_in_valid = 1'b1;
    rx_in_data  = b;
    tick();
    rx_in_valid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [7:0] data, input logic [3:0] strb);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    case (addr[3:2])
      2'd1: if (strb[0] && tx_m.size() < 16) tx_m.push_back(data);
      2'd3: begin
        if (data[0]) tx_m.delete();
        if (data[1]) rx_m.delete();
        intr_en_m = data[4];
      end
      default: ;
    endcase
    axi_awaddr = addr; axi_awvalid = 1'b1;
    axi_wdata = {24'hABCDEF, data}; axi_wstrb = strb; axi_wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = axi_awvalid && axi_awready;
      w_now  = axi_wvalid && axi_wready;
      tick(); n++;
      if (aw_now) begin axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin axi_wvalid = 1'b0; w_done = 1'b1; end
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    check("wr_bvalid", axi_bvalid, 1);
    check("wr_bresp", axi_bresp, 0);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [3:0] addr, input int hold,
                          input bit inj, input logic [7:0] inj_data);
    logic [31:0] e;
    int n;
    e = '0;
    case (addr[3:2])
      2'd0: if (rx_m.size() > 0) e = {24'b0, rx_m.pop_front()};
      2'd2: begin e = stat_model(); overrun_m = 1'b0; end
      default: e = '0;
    endcase
    if (inj) begin
      if (rx_m.size() < 16) rx_m.push_back(inj_data);
      else overrun_m = 1'b1;
    end
    exp_q.push_back(e);
    axi_araddr = addr; axi_arvalid = 1'b1;
    rx_in_valid = inj; rx_in_data = inj_data;
    n = 0;
    while (!axi_arready && n < 20) begin tick(); n++; end
    tick();
    axi_arvalid = 1'b0; rx_in_valid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 20) begin tick(); n++; end
    check({tag, "_rvalid"}, axi_rvalid, 1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_rvalid"}, axi_rvalid, 1);
      check({tag, "_hold_rdata"}, axi_rdata, exp_q[0]);
      check({tag, "_hold_arready"}, axi_arready, 0);
      tick();
    end
    axi_rready = 1'b1;
    check(tag, axi_rdata, exp_q.pop_front());
    check({tag, "_rresp"}, axi_rresp, 0);
    tick();
    axi_rready = 1'b0;
  endtask

  task automatic tx_drain();
    int n;
    tx_out_ready = 1'b1;
    while (tx_m.size() > 0) begin
      n = 0;
      while (!tx_out_valid && n < 20) begin tick(); n++; end
      check("tx_data", tx_out_data, tx_m.pop_front());
      tick();
    end
    tx_out_ready = 1'b0;
    check("tx_valid_after_drain", tx_out_valid, 0);
  endtask

  initial begin
    int pulses;
    tick(); tick();
    check("rst_awready", axi_awready, 1);
    check("rst_wready", axi_wready, 1);
    check("rst_arready", axi_arready, 1);
    check("rst_valids", {axi_bvalid, axi_rvalid, tx_out_valid, irq}, 4'b0000);
    check("rst_rdata", axi_rdata, 0);
    rst = 1'b0;
    tick();

    // two RX bytes, status and pops including an empty pop
    rx_push(8'h41);
    rx_push(8'h42);
    axi_read("stat_rx2", 4'h8, 0, 1'b0, 8'h00);
    axi_read("rx_0x41", 4'h0, 0, 1'b0, 8'h00);
    axi_read("rx_0x42", 4'h0, 0, 1'b0, 8'h00);
    axi_read("rx_empty", 4'h0, 0, 1'b0, 8'h00);
    axi_read("stat_idle", 4'h8, 0, 1'b0, 8'h00);
    axi_read("rd_tx_reg", 4'h4, 0, 1'b0, 8'h00);
    axi_read("rd_ctrl_reg", 4'hC, 0, 1'b0, 8'h00);

    // AW in cycle 0, W in cycle 3, response held with bready low
    tx_m.push_back(8'h55);
    axi_awaddr = 4'h4; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("split_awready_held", axi_awready, 0);
    check("split_bvalid_early", axi_bvalid, 0);
    tick(); tick();
    axi_wdata = 32'h0000_0055; axi_wstrb = 4'h1; axi_wvalid = 1'b1;
    check("split_wready", axi_wready, 1);
    tick();
    axi_wvalid = 1'b0;
    check("split_bvalid", axi_bvalid, 1);
    check("split_bresp", axi_bresp, 0);
    check("split_tx_valid", tx_out_valid, 1);
    check("split_tx_data", tx_out_data, 8'h55);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bhold_bvalid", axi_bvalid, 1);
      check("bhold_awready", axi_awready, 0);
      check("bhold_wready", axi_wready, 0);
    end
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check("b_done_bvalid", axi_bvalid, 0);
    check("b_done_awready", axi_awready, 1);
    tx_drain();

    // strobe-less write is dropped; overfill TX with 17 bytes
    axi_write(4'h4, 8'hAA, 4'h0);
    check("strb0_no_push", tx_out_valid, 0);
    for (int i = 0; i < 17; i++) axi_write(4'h4, 8'h60 + 8'(i), 4'h1);
    axi_read("stat_tx_full", 4'h8, 0, 1'b0, 8'h00);
    tx_drain();

    // overfill RX, then push and pop together while full
    for (int i = 0; i < 17; i++) rx_push(8'h10 + 8'(i));
    axi_read("stat_overrun", 4'h8, 0, 1'b0, 8'h00);
    axi_read("stat_overrun_cleared", 4'h8, 0, 1'b0, 8'h00);
    axi_read("rx_full_pushpop", 4'h0, 0, 1'b1, 8'hEE);
    axi_read("stat_still_full", 4'h8, 0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) axi_read("rx_drain", 4'h0, 0, 1'b0, 8'h00);
    axi_read("rx_drained_empty", 4'h0, 0, 1'b0, 8'h00);

    // interrupt on RX data arrival
    axi_write(4'hC, 8'h10, 4'h1);
    rx_m.push_back(8'h7F);
    rx_in_valid = 1'b1; rx_in_data = 8'h7F;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rx_in_valid = 1'b0;
      if (irq) pulses++;
    end
    check("irq_pulses", pulses, 1);

    // clear both FIFOs, keep interrupts enabled; held read response
    axi_write(4'hC, 8'h13, 4'h1);
    check("clr_tx_valid", tx_out_valid, 0);
    axi_read("stat_after_clr", 4'h8, 5, 1'b0, 8'h00);

    // reset in the middle of pending read and write transactions
    axi_write(4'h4, 8'h33, 4'h1);
    check("pre_rst_tx_valid", tx_out_valid, 1);
    axi_araddr = 4'h8; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    axi_awaddr = 4'h4; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wdata = 32'h99; axi_wvalid = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("midrst_valids", {axi_bvalid, axi_rvalid, tx_out_valid, irq}, 4'b0000);
    check("midrst_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
    check("midrst_rdata", axi_rdata, 0);
    axi_wvalid = 1'b0;
    tx_m.delete(); rx_m.delete(); intr_en_m = 1'b0; overrun_m = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_bvalid", axi_bvalid, 0);
    axi_read("stat_post_rst", 4'h8, 0, 1'b0, 8'h00);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
